clk_div_multi: RTL
==================

# clk_div_multi

Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the fixed single-output 1 Hz divider. Each of `NUM_CH` independent channels divides the system clock by a per-channel divisor and produces two outputs: a 50 %-duty toggled enable-clock and a one-cycle tick. Divisors can be reprogrammed glitch-free while a channel runs. The block sits between the board clock and slow consumers such as counters, SSD multiplexing and debouncers.

## Interface
- `NUM_CH`, default 2: number of channels.
- `DIV_W`, default 26: divisor/counter width.
- `DEF_DIV`, default 50_000_000: reset divisor for every channel. Gives 1 Hz `slow_clk` at 100 MHz.
- `clk`, in, 1: system clock. The block has one clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `ch_en`, in, `NUM_CH`: per-channel run enable.
- `sync_restart`, in, 1: realigns all channels to phase 0.
- `cfg_wr`, in, 1: single-cycle divisor write strobe. Always accepted.
- `cfg_ch`, in, `$clog2(NUM_CH)` (min 1): target channel for the write.
- `cfg_div`, in, `DIV_W`: new divisor value.
- `cfg_pend`, out, `NUM_CH`: written divisor is not yet applied.
- `slow_clk`, out, `NUM_CH`: toggled output, period 2·div cycles.
- `tick`, out, `NUM_CH`: one-cycle pulse, period div cycles.

## Operation
- Per-channel state:
  - `cnt[DIV_W]`
  - `div_act`: active divisor
  - `div_shd`: shadow divisor
  - `pend`
  - `slow_clk`
  - `tick`
- Effective divisor is `max(div_act, 1)`. A write of 0 behaves as 1.
- Terminal condition: `ch_en[i] && cnt == div_eff-1`.
- On terminal: `cnt <= 0`, `slow_clk` toggles, `tick <= 1`. On every other cycle `tick <= 0`. When enabled and not terminal, `cnt` increments.
- `ch_en[i]` low:
  - `cnt <= 0`, `slow_clk <= 0`, `tick <= 0`.
  - Re-enabling restarts from phase 0, so the first tick comes div cycles later.
- Divisor write: `div_shd[cfg_ch] <= cfg_div`, `pend <= 1`.
  - If the channel is running, `div_act <= div_shd` at the next terminal edge and `pend` clears on that edge.
  - If the channel is disabled, `div_act` loads directly and `pend` stays 0.
  - If `cfg_wr` coincides with that channel's terminal cycle, the new value is applied at that edge and `pend` stays 0.
  - `cfg_ch >= NUM_CH`: write ignored.
  - A second write before application overwrites `div_shd`; only the last value is applied.
- `sync_restart`: every channel gets `cnt <= 0`, `slow_clk <= 0`, `tick <= 0`, and any pending `div_shd` is applied immediately (`pend` cleared).
  - `cfg_wr` in the same cycle is applied immediately too.
  - `sync_restart` has priority over terminal in that cycle.
- Priority, highest first: `rst` > `sync_restart` > `!ch_en` > terminal > increment.

## Timing
- Reset values: `cnt` = 0, `div_act` = `div_shd` = `DEF_DIV`, `pend` = 0, `slow_clk` = 0, `tick` = 0.
- All outputs are registered. `tick` and the `slow_clk` edge appear the cycle after `cnt == div_eff-1` is seen.
- Steady state: tick period = div_eff cycles; `slow_clk` period = 2·div_eff cycles with exactly 50 % duty. div_eff = 1 gives `tick` constantly high and `slow_clk` = clk/2.
- `cfg_pend` rises the cycle after `cfg_wr` and falls the cycle after the applying edge.
- `rst` asserted mid-count returns the outputs above on the next edge.
- There is no state that survives reset.

## Structure
- Package `clk_div_pkg`:
  - `DIV_W` default
  - `DEF_DIV` default
  - function `div_eff(div)` implementing the zero-clamp
- Sub-module `clk_div_channel`:
  - Holds one channel's counter, divisor and shadow, and its outputs.
  - Ports: `clk`, `rst`, `en`, `restart`, `wr`, `wdata`, `pend`, `slow_clk`, `tick`.
  - The top level decodes `cfg_ch` into per-channel `wr` and instantiates the channel with a generate loop.

## Test plan
- **Reset defaults:** `rst` 3 cycles, `DEF_DIV` = 4, `ch_en` = 2'b11 → `tick` every 4 cycles, `slow_clk` period 8 with 4 high / 4 low; all outputs 0 during reset.
- **Running rewrite:** ch0 div = 4 running, write div = 2 mid-count at `cnt` = 1 → `cfg_pend[0]` high until the next terminal; next tick at the old 4-cycle spacing, thereafter 2; ch1 unaffected.
- **Zero divisor:** write div = 0 to a disabled channel, then enable → `tick` constantly 1, `slow_clk` toggles every cycle, `cfg_pend` never asserted.
- **Restart with write:** two channels with div = 3 and div = 5, pending write on ch1, `sync_restart` pulse → both counters 0, `slow_clk` = 0, new ch1 divisor active; first ticks at 3 and new-div cycles later.
- **Coincident events:** `cfg_wr` in the terminal cycle, and `cfg_wr` with `cfg_ch` out of range → first applies at that edge with `pend` = 0; second changes nothing.
- **Enable drop:** `ch_en` deasserted with `slow_clk` = 1 at `cnt` = 2 → next cycle `slow_clk` = 0, `cnt` = 0; re-enable gives first tick after div cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and the divisor zero-clamp for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned DEF_DIV_W   = 26;
  localparam int unsigned DEF_DIV_VAL = 50_000_000;
  localparam int unsigned DIV_MAX_W   = 32;

  // A programmed divisor of zero is treated as one.
  function automatic logic [DIV_MAX_W-1:0] div_eff(input logic [DIV_MAX_W-1:0] div);
    return (div == '0) ? DIV_MAX_W'(1) : div;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor, toggled clock and tick.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdata,
  output logic             pend,
  output logic             slow_clk,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_shd;
  logic             r_pend;
  logic             r_slow;
  logic             r_tick;

  logic [DIV_W-1:0] w_eff;
  logic [DIV_W-1:0] w_next_div;
  logic             w_term;

  assign w_eff      = DIV_W'(div_eff(DIV_MAX_W'(r_div_act)));
  assign w_term     = en && (r_cnt == (w_eff - DIV_W'(1)));
  // A write in the same cycle as an applying event wins over the older shadow.
  assign w_next_div = wr ? wdata : r_div_shd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_div_act <= DIV_W'(DEF_DIV);
      r_div_shd <= DIV_W'(DEF_DIV);
      r_pend    <= 1'b0;
      r_slow    <= 1'b0;
      r_tick    <= 1'b0;
    end else if (restart || !en) begin
      r_cnt     <= '0;
      r_slow    <= 1'b0;
      r_tick    <= 1'b0;
      r_div_act <= w_next_div;
      r_div_shd <= w_next_div;
      r_pend    <= 1'b0;
    end else if (w_term) begin
      r_cnt     <= '0;
      r_slow    <= ~r_slow;
      r_tick    <= 1'b1;
      r_div_act <= w_next_div;
      r_div_shd <= w_next_div;
      r_pend    <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
      if (wr) begin
        r_div_shd <= wdata;
        r_pend    <= 1'b1;
      end
    end
  end

  assign pend     = r_pend;
  assign slow_clk = r_slow;
  assign tick     = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider; decodes divisor writes per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned DIV_W   = DEF_DIV_W,
  parameter  int unsigned DEF_DIV = DEF_DIV_VAL,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [NUM_CH-1:0] slow_clk,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_wr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Indices at or above NUM_CH match no channel, so such writes are dropped.
    assign w_wr[g] = cfg_wr && (cfg_ch == CH_W'(g));

    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[g]),
      .restart  (sync_restart),
      .wr       (w_wr[g]),
      .wdata    (cfg_div),
      .pend     (cfg_pend[g]),
      .slow_clk (slow_clk[g]),
      .tick     (tick[g])
    );
  end

endmodule
